audio_capture_sequencer: RTL and testbench

// - Sequences mic sample capture from the two I2S receivers (left/right mic words) into the CLK domain.
// - Detects frame boundaries on AUD_ADCLRCK, waits for data to settle, and pushes stereo pairs into a FIFO that the HPS drains over Avalon-MM.
// - Drives codec_left/codec_right from either the latest captured pair or HPS override registers.

---
 rtl/audio_capture_sequencer_if.sv | 19 +
 rtl/audio_capture_sequencer.sv | 232 +++++++++++++++++++++++
 tb/tb_audio_capture_sequencer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/audio_capture_sequencer_if.sv
// Avalon-MM register port used by the HPS to configure the sequencer and drain its stereo FIFO.
interface audio_capture_sequencer_if;
    logic        AVL_READ;
    logic        AVL_WRITE;
    logic        AVL_CS;
    logic [3:0]  AVL_ADDR;
    logic [31:0] AVL_WRITEDATA;
    logic [31:0] AVL_READDATA;

    modport master (
        output AVL_READ, AVL_WRITE, AVL_CS, AVL_ADDR, AVL_WRITEDATA,
        input  AVL_READDATA
    );

    modport slave (
        input  AVL_READ, AVL_WRITE, AVL_CS, AVL_ADDR, AVL_WRITEDATA,
        output AVL_READDATA
    );
endinterface

// File: rtl/audio_capture_sequencer.sv
// Captures I2S mic pairs on WS frame edges into a stereo FIFO drained over Avalon-MM.
// Optional macro AUDIO_SEQ_FRAME_COUNT_EN adds a 32-bit frame counter at register 7.
//
// state   | meaning
// IDLE    | capture disabled (CTRL.en = 0)
// ARMED   | waiting for a falling edge of the synced word select
// SETTLE  | letting the mic words settle after the frame edge
// CAPTURE | latch the mic pair into last_* and push it into the FIFO
module audio_capture_sequencer #(
    parameter int FIFO_DEPTH    = 16,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        AUD_ADCLRCK,
    input  logic [31:0] mic_left,
    input  logic [31:0] mic_right,
    audio_capture_sequencer_if.slave avl,
    output logic [31:0] codec_left,
    output logic [31:0] codec_right,
    output logic        irq
);
    localparam int             PW          = $clog2(FIFO_DEPTH);
    localparam logic [8:0]     DEPTH_C     = 9'(FIFO_DEPTH);
    localparam logic [7:0]     SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
    localparam logic [PW-1:0]  PTR_ONE     = PW'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        SETTLE  = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    state_t      state, state_next;
    logic [7:0]  settle_cnt;
    logic        load_settle, capture;

    logic        ws_s1, ws_s2, ws_d;
    logic        frame_edge;

    logic        ctrl_en, ctrl_override, ctrl_irq_en;
    logic [31:0] ovr_l, ovr_r;
    logic [8:0]  thresh;
    logic [31:0] last_l, last_r;

    logic [31:0] mem_l [FIFO_DEPTH];
    logic [31:0] mem_r [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [8:0]  count;
    logic        overflow, underflow;

    logic        rd_en, wr_en, pop_req, pop, push_ok, clear, w1c;
    logic        fifo_empty, fifo_full;
    logic [31:0] rdata;

    // WS is asynchronous to CLK; the frame edge is the falling edge after synchronisation.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ws_s1 <= 1'b0;
            ws_s2 <= 1'b0;
            ws_d  <= 1'b0;
        end else begin
            ws_s1 <= AUD_ADCLRCK;
            ws_s2 <= ws_s1;
            ws_d  <= ws_s2;
        end
    end

    assign frame_edge = ws_d & ~ws_s2;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= IDLE;
            settle_cnt <= 8'd0;
        end else begin
            state <= state_next;
            if (load_settle)
                settle_cnt <= SETTLE_LOAD;
            else if (state == SETTLE && settle_cnt != 8'd0)
                settle_cnt <= settle_cnt - 8'd1;
        end
    end

    always_comb begin
        state_next  = state;
        load_settle = 1'b0;
        capture     = 1'b0;
        if (!ctrl_en) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    state_next = ARMED;
                ARMED: begin
                    if (frame_edge) begin
                        state_next  = SETTLE;
                        load_settle = 1'b1;
                    end
                end
                SETTLE:  if (settle_cnt == 8'd0) state_next = CAPTURE;
                CAPTURE: begin
                    capture    = 1'b1;
                    state_next = ARMED;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign rd_en      = avl.AVL_CS & avl.AVL_READ;
    assign wr_en      = avl.AVL_CS & avl.AVL_WRITE;
    assign pop_req    = rd_en & (avl.AVL_ADDR == 4'd3);
    assign fifo_empty = (count == 9'd0);
    assign fifo_full  = (count == DEPTH_C);
    assign pop        = pop_req & ~fifo_empty;
    assign push_ok    = capture & (~fifo_full | pop);
    assign clear      = wr_en & (avl.AVL_ADDR == 4'd0) & avl.AVL_WRITEDATA[2];
    assign w1c        = wr_en & (avl.AVL_ADDR == 4'd1);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            ctrl_en       <= 1'b0;
            ctrl_override <= 1'b0;
            ctrl_irq_en   <= 1'b0;
            ovr_l         <= 32'd0;
            ovr_r         <= 32'd0;
            thresh        <= 9'd0;
        end else if (wr_en) begin
            case (avl.AVL_ADDR)
                4'd0: begin
                    ctrl_en       <= avl.AVL_WRITEDATA[0];
                    ctrl_override <= avl.AVL_WRITEDATA[1];
                    ctrl_irq_en   <= avl.AVL_WRITEDATA[3];
                end
                4'd4:    ovr_l  <= avl.AVL_WRITEDATA;
                4'd5:    ovr_r  <= avl.AVL_WRITEDATA;
                4'd6:    thresh <= avl.AVL_WRITEDATA[8:0];
                default: ;
            endcase
        end
    end

    // Storage has no reset; entries are only visible while count says they are valid.
    always_ff @(posedge CLK) begin
        if (push_ok && !clear) begin
            mem_l[wr_ptr] <= mic_left;
            mem_r[wr_ptr] <= mic_right;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 9'd0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
            case ({push_ok, pop})
                2'b10:   count <= count + 9'd1;
                2'b01:   count <= count - 9'd1;
                default: ;
            endcase
        end
    end

    // A set in the same cycle as a write-one-to-clear keeps the flag.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (capture & fifo_full & ~pop & ~clear)
                       | (overflow & ~(w1c & avl.AVL_WRITEDATA[24]));
            underflow <= (pop_req & fifo_empty)
                       | (underflow & ~(w1c & avl.AVL_WRITEDATA[25]));
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            last_l      <= 32'd0;
            last_r      <= 32'd0;
            codec_left  <= 32'd0;
            codec_right <= 32'd0;
            irq         <= 1'b0;
        end else begin
            if (capture) begin
                last_l <= mic_left;
                last_r <= mic_right;
            end
            codec_left  <= ctrl_override ? ovr_l : last_l;
            codec_right <= ctrl_override ? ovr_r : last_r;
            irq         <= ctrl_irq_en & (((count >= thresh) & (thresh != 9'd0)) | overflow);
        end
    end

`ifdef AUDIO_SEQ_FRAME_COUNT_EN
    logic [31:0] frame_cnt;

    always_ff @(posedge CLK) begin
        if (RESET)
            frame_cnt <= 32'd0;
        else if (wr_en && avl.AVL_ADDR == 4'd7)
            frame_cnt <= 32'd0;
        else if (frame_edge && ctrl_en)
            frame_cnt <= frame_cnt + 32'd1;
    end
`endif

    always_comb begin
        rdata = 32'd0;
        if (rd_en) begin
            case (avl.AVL_ADDR)
                4'd0: rdata = {28'd0, ctrl_irq_en, 1'b0, ctrl_override, ctrl_en};
                4'd1: rdata = {6'd0, underflow, overflow, 6'd0, fifo_full, fifo_empty, 7'd0, count};
                4'd2: rdata = fifo_empty ? 32'd0 : mem_l[rd_ptr];
                4'd3: rdata = fifo_empty ? 32'd0 : mem_r[rd_ptr];
                4'd4: rdata = ovr_l;
                4'd5: rdata = ovr_r;
                4'd6: rdata = {23'd0, thresh};
`ifdef AUDIO_SEQ_FRAME_COUNT_EN
                4'd7: rdata = frame_cnt;
`endif
                default: rdata = 32'd0;
            endcase
        end
    end

    assign avl.AVL_READDATA = rdata;

endmodule

// File: tb/tb_audio_capture_sequencer.sv
// Scoreboard bench for audio_capture_sequencer: stimulus queues expected values, a negedge monitor checks them.
module tb_audio_capture_sequencer;
    logic        CLK = 1'b0;
    logic        RESET;
    logic        AUD_ADCLRCK;
    logic [31:0] mic_left, mic_right;
    logic [31:0] codec_left, codec_right;
    logic        irq;
    logic        probe;

    int errors = 0;
    int checks = 0;

    logic [31:0] sb_exp  [$];
    int          sb_kind [$];
    string       sb_name [$];

    audio_capture_sequencer_if avl ();

    audio_capture_sequencer #(.FIFO_DEPTH(16), .SETTLE_CYCLES(4)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .AUD_ADCLRCK (AUD_ADCLRCK),
        .mic_left    (mic_left),
        .mic_right   (mic_right),
        .avl         (avl),
        .codec_left  (codec_left),
        .codec_right (codec_right),
        .irq         (irq)
    );

    always #5 CLK = ~CLK;

    // kind 0: read data, 1: codec_left, 2: codec_right, 3: irq
    always @(negedge CLK) begin
        logic [31:0] e, act;
        int          k;
        string       n;
        if ((avl.AVL_CS && avl.AVL_READ) || probe) begin
            checks++;
            if (sb_exp.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: DUT output with no expectation queued at %0t", $time);
            end else begin
                e = sb_exp.pop_front();
                k = sb_kind.pop_front();
                n = sb_name.pop_front();
                case (k)
                    0:       act = avl.AVL_READDATA;
                    1:       act = codec_left;
                    2:       act = codec_right;
                    default: act = {31'd0, irq};
                endcase
                if (act !== e) begin
                    errors++;
                    $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", n, act, e, $time);
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] e, input string n);
        sb_exp.push_back(e);
        sb_kind.push_back(0);
        sb_name.push_back(n);
        avl.AVL_ADDR = a;
        avl.AVL_CS   = 1'b1;
        avl.AVL_READ = 1'b1;
        tick();
        avl.AVL_CS   = 1'b0;
        avl.AVL_READ = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        avl.AVL_ADDR      = a;
        avl.AVL_WRITEDATA = d;
        avl.AVL_CS        = 1'b1;
        avl.AVL_WRITE     = 1'b1;
        tick();
        avl.AVL_CS        = 1'b0;
        avl.AVL_WRITE     = 1'b0;
    endtask

    task automatic chk(input int k, input logic [31:0] e, input string n);
        sb_exp.push_back(e);
        sb_kind.push_back(k);
        sb_name.push_back(n);
        probe = 1'b1;
        tick();
        probe = 1'b0;
    endtask

    task automatic frame(input logic [31:0] l, input logic [31:0] r);
        mic_left    = l;
        mic_right   = r;
        AUD_ADCLRCK = 1'b1;
        repeat (4) tick();
        AUD_ADCLRCK = 1'b0;
        repeat (10) tick();
    endtask

    initial begin
        RESET             = 1'b1;
        AUD_ADCLRCK       = 1'b1;
        mic_left          = 32'd0;
        mic_right         = 32'd0;
        probe             = 1'b0;
        avl.AVL_CS        = 1'b0;
        avl.AVL_READ      = 1'b0;
        avl.AVL_WRITE     = 1'b0;
        avl.AVL_ADDR      = 4'd0;
        avl.AVL_WRITEDATA = 32'd0;
        repeat (3) tick();
        RESET = 1'b0;

        // Reset state
        chk(1, 32'h0, "rst_codec_l");
        chk(2, 32'h0, "rst_codec_r");
        chk(3, 32'h0, "rst_irq");
        rd(4'd1, 32'h0001_0000, "rst_status");
        rd(4'd0, 32'h0, "rst_ctrl");
        wr(4'd9, 32'hFFFF_FFFF);
        rd(4'd9, 32'h0, "addr9_reads0");
        rd(4'd7, 32'h0, "addr7_reads0");
        wr(4'd0, 32'h1);

        // T1: latency and single-pair path
        mic_left  = 32'h1111;
        mic_right = 32'h2222;
        AUD_ADCLRCK = 1'b0;
        repeat (7) tick();
        rd(4'd1, 32'h0001_0000, "t1_count_before_push");
        rd(4'd1, 32'h0000_0001, "t1_count_after_push");
        rd(4'd2, 32'h1111, "t1_head_l");
        rd(4'd3, 32'h2222, "t1_head_r_pop");
        rd(4'd1, 32'h0001_0000, "t1_empty_after_pop");
        chk(1, 32'h1111, "t1_codec_l_last");

        // T2: fill and overflow
        for (int i = 0; i < 16; i++) frame(32'h100 + i, 32'h200 + i);
        rd(4'd1, 32'h0002_0010, "t2_full");
        frame(32'h110, 32'h210);
        rd(4'd1, 32'h0102_0010, "t2_overflow");
        rd(4'd2, 32'h100, "t2_head_still_first");
        wr(4'd1, 32'h0100_0000);
        rd(4'd1, 32'h0002_0010, "t2_ovf_w1c");

        // T3: pop coincides with CAPTURE while full
        mic_left    = 32'h333;
        mic_right   = 32'h444;
        AUD_ADCLRCK = 1'b1;
        repeat (4) tick();
        AUD_ADCLRCK = 1'b0;
        repeat (7) tick();
        rd(4'd3, 32'h200, "t3_pop_at_capture");
        repeat (2) tick();
        rd(4'd1, 32'h0002_0010, "t3_still_full_no_ovf");
        for (int i = 1; i < 16; i++) rd(4'd3, 32'h200 + i, "t3_drain");
        rd(4'd2, 32'h333, "t3_tail_l");
        rd(4'd3, 32'h444, "t3_tail_r");
        rd(4'd1, 32'h0001_0000, "t3_empty");

        // T4: underflow
        rd(4'd3, 32'h0, "t4_pop_empty");
        rd(4'd1, 32'h0201_0000, "t4_underflow");
        wr(4'd1, 32'h0200_0000);
        rd(4'd1, 32'h0001_0000, "t4_udf_w1c");

        // T5: override
        wr(4'd4, 32'hABCD);
        wr(4'd5, 32'h1234);
        rd(4'd4, 32'hABCD, "t5_ovr_l_rb");
        wr(4'd0, 32'h3);
        chk(1, 32'h333, "t5_codec_l_pre");
        chk(1, 32'hABCD, "t5_codec_l_ovr");
        chk(2, 32'h1234, "t5_codec_r_ovr");
        wr(4'd0, 32'h1);
        chk(1, 32'hABCD, "t5_codec_l_hold");
        chk(1, 32'h333, "t5_codec_l_revert");
        chk(2, 32'h444, "t5_codec_r_revert");

        // T6: threshold irq, clear, reset mid-settle
        wr(4'd6, 32'h2);
        wr(4'd0, 32'h9);
        frame(32'h55, 32'h66);
        chk(3, 32'h0, "t6_irq_below");
        frame(32'h77, 32'h88);
        chk(3, 32'h1, "t6_irq_at_thresh");
        rd(4'd3, 32'h66, "t6_pop");
        tick();
        chk(3, 32'h0, "t6_irq_after_pop");
        wr(4'd0, 32'hD);
        rd(4'd1, 32'h0001_0000, "t6_clear_empty");
        rd(4'd0, 32'h9, "t6_clear_reads0");

        mic_left    = 32'hDEAD;
        mic_right   = 32'hBEEF;
        AUD_ADCLRCK = 1'b1;
        repeat (4) tick();
        AUD_ADCLRCK = 1'b0;
        repeat (4) tick();
        RESET = 1'b1;
        repeat (2) tick();
        RESET = 1'b0;
        repeat (10) tick();
        chk(1, 32'h0, "t6_rst_codec_l");
        chk(2, 32'h0, "t6_rst_codec_r");
        chk(3, 32'h0, "t6_rst_irq");
        rd(4'd1, 32'h0001_0000, "t6_rst_status");
        rd(4'd0, 32'h0, "t6_rst_ctrl");
        rd(4'd4, 32'h0, "t6_rst_ovr_l");
        wr(4'd0, 32'h1);
        repeat (10) tick();
        rd(4'd1, 32'h0001_0000, "t6_no_spurious_push");

        repeat (3) tick();
        if (sb_exp.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb_exp.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
